bus_master_arbiter: RTL and testbench

Parametrised bus master front-end that lets NUM_CH independent requesters share the single CPU system bus. Typical requesters are instruction fetch and load/store, with extra channels reserved for a future DMA or debug port. The block arbitrates round-robin and drives one outstanding transaction at a time using the bus DV handshake. It routes each response back to the channel that issued it, with an optional watchdog for bus responses that never arrive.

---
 rtl/bus_master_arbiter_pkg.sv | 28 ++
 rtl/bus_master_arbiter_rr_arbiter.sv | 35 +++
 rtl/bus_master_arbiter.sv | 151 +++++++++++++++
 tb/tb_bus_master_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_arbiter_pkg.sv
// Shared definitions for the bus master arbiter: FSM state encoding,
// bus size codes and a pointer-width helper.
package bus_master_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } state_t;

  localparam logic [2:0] BHW_B  = 3'b000;
  localparam logic [2:0] BHW_H  = 3'b001;
  localparam logic [2:0] BHW_W  = 3'b010;
  localparam logic [2:0] BHW_BU = 3'b100;
  localparam logic [2:0] BHW_HU = 3'b101;

  // A single-channel build still needs a 1-bit index.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid channel at or after rr_ptr,
// wrapping around, as one-hot grant plus binary index.
module bus_master_arbiter_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = 1
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [PTR_W-1:0]  grant_idx,
  output logic              any_valid
);

  int               cand;
  logic [PTR_W-1:0] sel;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = 0;
    sel       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      sel = PTR_W'(cand);
      if (!any_valid && valid[sel]) begin
        any_valid      = 1'b1;
        grant_idx      = sel;
        grant[sel]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// Round-robin bus master front-end: NUM_CH requesters share one bus, one
// outstanding transaction at a time. Optional response watchdog: BUS_TIMEOUT_EN.
module bus_master_arbiter
  import bus_master_arbiter_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_req_valid,
  input  logic [NUM_CH*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_CH*DATA_W-1:0] i_req_wdata,
  input  logic [NUM_CH*3-1:0]      i_req_bhw,
  input  logic [NUM_CH-1:0]        i_req_write,
  output logic [NUM_CH-1:0]        o_req_ready,
  output logic [NUM_CH-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]        o_rsp_data,
  output logic                     o_rsp_err,
  output logic [ADDR_W-1:0]        o_bus_address,
  output logic [DATA_W-1:0]        o_bus_data,
  output logic                     o_bus_DV,
  output logic [2:0]               o_bhw,
  output logic                     o_write_notread,
  input  logic [DATA_W-1:0]        i_bus_data,
  input  logic                     i_bus_DV
);

  localparam int               PTR_W   = ptr_width(NUM_CH);
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_q;
  logic [NUM_CH-1:0] grant_oh_q;
  logic [NUM_CH-1:0] arb_grant;
  logic [PTR_W-1:0]  arb_idx;
  logic              arb_any;
  logic              timeout_hit;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_bhw;
  logic              sel_write;

  bus_master_arbiter_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_rr_arbiter (
    .valid     (i_req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_valid (arb_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_bhw   = '0;
    sel_write = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (arb_idx == PTR_W'(c)) begin
        sel_addr  = i_req_addr[c*ADDR_W +: ADDR_W];
        sel_wdata = i_req_wdata[c*DATA_W +: DATA_W];
        sel_bhw   = i_req_bhw[c*3 +: 3];
        sel_write = i_req_write[c];
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  // A bus answer arriving on the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state == WAIT) && !i_bus_DV && (to_cnt == TO_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      to_cnt    <= '0;
      o_rsp_err <= 1'b0;
    end else begin
      if ((state == WAIT) && !i_bus_DV && !timeout_hit) to_cnt <= to_cnt + TO_W'(1);
      else                                              to_cnt <= '0;
      o_rsp_err <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_rsp_err   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      grant_q         <= '0;
      grant_oh_q      <= '0;
      o_req_ready     <= '0;
      o_rsp_valid     <= '0;
      o_rsp_data      <= '0;
      o_bus_address   <= '0;
      o_bus_data      <= '0;
      o_bus_DV        <= 1'b0;
      o_bhw           <= '0;
      o_write_notread <= 1'b0;
    end else begin
      o_req_ready <= '0;
      o_rsp_valid <= '0;
      o_bus_DV    <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_q         <= arb_idx;
            grant_oh_q      <= arb_grant;
            o_bus_address   <= sel_addr;
            o_bus_data      <= sel_wdata;
            o_bhw           <= sel_bhw;
            o_write_notread <= sel_write;
            o_bus_DV        <= 1'b1;
            o_req_ready     <= arb_grant;
            state           <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (i_bus_DV) begin
            o_rsp_data  <= i_bus_data;
            o_rsp_valid <= grant_oh_q;
            state       <= RESP;
          end else if (timeout_hit) begin
            o_rsp_data  <= '0;
            o_rsp_valid <= grant_oh_q;
            state       <= RESP;
          end
        end
        RESP: begin
          rr_ptr <= (grant_q == LAST_CH) ? '0 : grant_q + PTR_W'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed + randomized bench for bus_master_arbiter (4 channels) against a
// transaction-level round-robin model.
module tb_bus_master_arbiter;
  import bus_master_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              i_clk;
  logic              i_rst;
  logic [N-1:0]      i_req_valid;
  logic [N*AW-1:0]   i_req_addr;
  logic [N*DW-1:0]   i_req_wdata;
  logic [N*3-1:0]    i_req_bhw;
  logic [N-1:0]      i_req_write;
  logic [N-1:0]      o_req_ready;
  logic [N-1:0]      o_rsp_valid;
  logic [DW-1:0]     o_rsp_data;
  logic              o_rsp_err;
  logic [AW-1:0]     o_bus_address;
  logic [DW-1:0]     o_bus_data;
  logic              o_bus_DV;
  logic [2:0]        o_bhw;
  logic              o_write_notread;
  logic [DW-1:0]     i_bus_data;
  logic              i_bus_DV;

  logic [AW-1:0] addr_a  [N];
  logic [DW-1:0] wdata_a [N];
  logic [2:0]    bhw_a   [N];
  logic          wr_a    [N];

  int checks = 0;
  int errors = 0;
  int rr_ptr_m = 0;

  bus_master_arbiter #(
    .NUM_CH         (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_req_valid     (i_req_valid),
    .i_req_addr      (i_req_addr),
    .i_req_wdata     (i_req_wdata),
    .i_req_bhw       (i_req_bhw),
    .i_req_write     (i_req_write),
    .o_req_ready     (o_req_ready),
    .o_rsp_valid     (o_rsp_valid),
    .o_rsp_data      (o_rsp_data),
    .o_rsp_err       (o_rsp_err),
    .o_bus_address   (o_bus_address),
    .o_bus_data      (o_bus_data),
    .o_bus_DV        (o_bus_DV),
    .o_bhw           (o_bhw),
    .o_write_notread (o_write_notread),
    .i_bus_data      (i_bus_data),
    .i_bus_DV        (i_bus_DV)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always_comb begin
    i_req_addr  = '0;
    i_req_wdata = '0;
    i_req_bhw   = '0;
    i_req_write = '0;
    for (int c = 0; c < N; c++) begin
      i_req_addr[c*AW +: AW]  = addr_a[c];
      i_req_wdata[c*DW +: DW] = wdata_a[c];
      i_req_bhw[c*3 +: 3]     = bhw_a[c];
      i_req_write[c]          = wr_a[c];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requesting channel at or after the pointer, wrapping.
  function automatic int model_grant(input logic [N-1:0] m, input int ptr);
    for (int i = 0; i < N; i++)
      if (m[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic randomize_fields();
    for (int c = 0; c < N; c++) begin
      addr_a[c]  = $urandom;
      wdata_a[c] = $urandom;
      bhw_a[c]   = 3'($urandom_range(0, 7));
      wr_a[c]    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dv"},    64'(o_bus_DV), 64'(0));
    check({tag, "_ready"}, 64'(o_req_ready), 64'(0));
    check({tag, "_rspv"},  64'(o_rsp_valid), 64'(0));
    check({tag, "_rspd"},  64'(o_rsp_data), 64'(0));
    check({tag, "_err"},   64'(o_rsp_err), 64'(0));
    check({tag, "_addr"},  64'(o_bus_address), 64'(0));
    check({tag, "_data"},  64'(o_bus_data), 64'(0));
    check({tag, "_bhw"},   64'(o_bhw), 64'(0));
    check({tag, "_wnr"},   64'(o_write_notread), 64'(0));
  endtask

  // One complete transaction: request on the current negedge, issue, wait
  // 'delay' extra cycles, bus answers, response, back to idle.
  task automatic run_txn(input logic [N-1:0] mask, input bit hold, input int delay,
                         input logic [DW-1:0] rdata, input bit dv_issue, output int g_obs);
    int            g;
    logic [N-1:0]  oh;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [2:0]    e_bhw;
    logic          e_wr;
    g  = model_grant(mask, rr_ptr_m);
    if (g < 0) g = 0;
    oh = '0;
    oh[g] = 1'b1;
    e_addr = addr_a[g]; e_wdata = wdata_a[g]; e_bhw = bhw_a[g]; e_wr = wr_a[g];
    i_req_valid = mask;
    @(negedge i_clk);
    g_obs = -1;
    for (int c = 0; c < N; c++) if (o_req_ready[c]) g_obs = c;
    check("issue_dv", 64'(o_bus_DV), 64'(1));
    check("req_ready", 64'(o_req_ready), 64'(oh));
    check("bus_addr", 64'(o_bus_address), 64'(e_addr));
    check("bus_data", 64'(o_bus_data), 64'(e_wdata));
    check("bus_bhw", 64'(o_bhw), 64'(e_bhw));
    check("bus_wnr", 64'(o_write_notread), 64'(e_wr));
    if (!hold) begin
      i_req_valid[g] = 1'b0;
      addr_a[g] = $urandom; wdata_a[g] = $urandom; bhw_a[g] = ~bhw_a[g]; wr_a[g] = ~wr_a[g];
    end
    if (dv_issue) begin
      i_bus_DV = 1'b1;
      i_bus_data = $urandom;
    end
    @(negedge i_clk);
    i_bus_DV = 1'b0;
    check("dv_pulse", 64'(o_bus_DV), 64'(0));
    check("ready_pulse", 64'(o_req_ready), 64'(0));
    check("addr_hold", 64'(o_bus_address), 64'(e_addr));
    check("wdata_hold", 64'(o_bus_data), 64'(e_wdata));
    check("wait_rspv", 64'(o_rsp_valid), 64'(0));
    repeat (delay) begin
      @(negedge i_clk);
      check("wait_rspv", 64'(o_rsp_valid), 64'(0));
    end
    i_bus_DV = 1'b1;
    i_bus_data = rdata;
    @(negedge i_clk);
    i_bus_DV = 1'b0;
    i_bus_data = $urandom;
    check("rsp_valid", 64'(o_rsp_valid), 64'(oh));
    check("rsp_data", 64'(o_rsp_data), 64'(rdata));
    check("rsp_err", 64'(o_rsp_err), 64'(0));
    rr_ptr_m = (g + 1) % N;
    @(negedge i_clk);
    check("rsp_pulse", 64'(o_rsp_valid), 64'(0));
  endtask

  int rr_seq [4] = '{0, 1, 0, 1};
  int g_obs;
  int gm;

  initial begin
    i_rst = 1'b1;
    i_req_valid = '0;
    i_bus_DV = 1'b0;
    i_bus_data = '0;
    randomize_fields();
    repeat (3) @(negedge i_clk);
    check_reset_outputs("rst");
    i_rst = 1'b0;
    @(negedge i_clk);
    check_reset_outputs("post_rst");

    // Two channels held valid: strict alternation from pointer 0.
    for (int k = 0; k < 4; k++) begin
      randomize_fields();
      run_txn(4'b0011, 1'b1, k % 3, $urandom, 1'b0, g_obs);
      check("rr_order", 64'(g_obs), 64'(rr_seq[k]));
    end
    // Channels 1 and 3 with pointer at 2: 3 first, then 1.
    randomize_fields();
    run_txn(4'b1010, 1'b1, 0, $urandom, 1'b0, g_obs);
    check("skip_order0", 64'(g_obs), 64'(3));
    run_txn(4'b1010, 1'b1, 1, $urandom, 1'b0, g_obs);
    check("skip_order1", 64'(g_obs), 64'(1));
    i_req_valid = '0;

    // Single read on channel 0, bus answers two cycles after the strobe.
    addr_a[0] = 32'h0000_1000; wr_a[0] = 1'b0; bhw_a[0] = BHW_W;
    run_txn(4'b0001, 1'b0, 1, 32'hDEAD_BEEF, 1'b0, g_obs);
    check("read_ch0", 64'(g_obs), 64'(0));

    // Write on channel 1.
    addr_a[1] = 32'h10; wdata_a[1] = 32'h1234_5678; bhw_a[1] = BHW_H; wr_a[1] = 1'b1;
    run_txn(4'b0010, 1'b0, 0, 32'hCAFE_0001, 1'b0, g_obs);
    check("write_ch1", 64'(g_obs), 64'(1));

    // Reset during WAIT abandons the transaction; pointer restarts at 0.
    randomize_fields();
    i_req_valid = 4'b0100;
    @(negedge i_clk);
    check("rst_txn_ready", 64'(o_req_ready), 64'(4'b0100));
    i_req_valid = '0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_reset_outputs("mid_rst");
    i_rst = 1'b0;
    i_bus_DV = 1'b1;
    i_bus_data = 32'h5555_AAAA;
    @(negedge i_clk);
    check("late_dv_rspv", 64'(o_rsp_valid), 64'(0));
    i_bus_DV = 1'b0;
    @(negedge i_clk);
    check("late_dv_rspv2", 64'(o_rsp_valid), 64'(0));
    check("late_dv_busdv", 64'(o_bus_DV), 64'(0));
    rr_ptr_m = 0;
    randomize_fields();
    run_txn(4'b1010, 1'b0, 0, $urandom, 1'b0, g_obs);
    check("after_rst_grant", 64'(g_obs), 64'(1));

    // Randomized traffic against the model.
    for (int k = 0; k < 40; k++) begin
      randomize_fields();
      run_txn(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 5),
              $urandom, 1'($urandom_range(0, 1)), g_obs);
    end
    i_req_valid = '0;

    // Bus strobe while idle must not produce a response.
    i_bus_DV = 1'b1;
    i_bus_data = 32'h0BAD_F00D;
    @(negedge i_clk);
    i_bus_DV = 1'b0;
    @(negedge i_clk);
    check("idle_dv_rspv", 64'(o_rsp_valid), 64'(0));
    check("idle_dv_busdv", 64'(o_bus_DV), 64'(0));

`ifdef BUS_TIMEOUT_EN
    // No answer: error response after TO wait cycles.
    randomize_fields();
    gm = model_grant(4'b0001, rr_ptr_m);
    i_req_valid = 4'b0001;
    @(negedge i_clk);
    check("to_ready", 64'(o_req_ready), 64'(4'b0001));
    i_req_valid = '0;
    for (int j = 1; j <= TO; j++) begin
      @(negedge i_clk);
      check("to_wait_rspv", 64'(o_rsp_valid), 64'(0));
    end
    @(negedge i_clk);
    check("to_rspv", 64'(o_rsp_valid), 64'(1) << gm);
    check("to_err", 64'(o_rsp_err), 64'(1));
    check("to_data", 64'(o_rsp_data), 64'(0));
    rr_ptr_m = (gm + 1) % N;
    @(negedge i_clk);
    check("to_rsp_pulse", 64'(o_rsp_valid), 64'(0));
    check("to_err_pulse", 64'(o_rsp_err), 64'(0));

    // Answer on the expiry cycle wins.
    randomize_fields();
    gm = model_grant(4'b1000, rr_ptr_m);
    i_req_valid = 4'b1000;
    @(negedge i_clk);
    check("tox_ready", 64'(o_req_ready), 64'(4'b1000));
    i_req_valid = '0;
    for (int j = 1; j <= TO; j++) begin
      @(negedge i_clk);
      check("tox_wait_rspv", 64'(o_rsp_valid), 64'(0));
      if (j == TO) begin
        i_bus_DV = 1'b1;
        i_bus_data = 32'hA5A5_0F0F;
      end
    end
    @(negedge i_clk);
    i_bus_DV = 1'b0;
    check("tox_rspv", 64'(o_rsp_valid), 64'(1) << gm);
    check("tox_err", 64'(o_rsp_err), 64'(0));
    check("tox_data", 64'(o_rsp_data), 64'(32'hA5A5_0F0F));
    rr_ptr_m = (gm + 1) % N;
    @(negedge i_clk);
`else
    // Without the watchdog a slow bus simply keeps the block waiting.
    randomize_fields();
    gm = model_grant(4'b0100, rr_ptr_m);
    i_req_valid = 4'b0100;
    @(negedge i_clk);
    check("slow_ready", 64'(o_req_ready), 64'(4'b0100));
    i_req_valid = '0;
    for (int j = 0; j < 20; j++) begin
      @(negedge i_clk);
      check("slow_wait_rspv", 64'(o_rsp_valid), 64'(0));
    end
    i_bus_DV = 1'b1;
    i_bus_data = 32'h7777_1234;
    @(negedge i_clk);
    i_bus_DV = 1'b0;
    check("slow_rspv", 64'(o_rsp_valid), 64'(1) << gm);
    check("slow_err", 64'(o_rsp_err), 64'(0));
    check("slow_data", 64'(o_rsp_data), 64'(32'h7777_1234));
    rr_ptr_m = (gm + 1) % N;
    @(negedge i_clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
